// File: rtl/shared_reg_arbiter_if.sv
// Bus between requesters and the shared-register arbiter.
// master: requester side (drives requests/data/stall); slave: arbiter side.
interface shared_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wr_data;
  logic                     stall;
  logic [NUM_REQ-1:0]       gnt;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_in;
  logic                     busy;
  logic [CNT_W-1:0]         grant_cnt;

  modport master (
    output req, wr_data, stall,
    input  gnt, reg_en, reg_in, busy, grant_cnt
  );

  modport slave (
    input  req, wr_data, stall,
    output gnt, reg_en, reg_in, busy, grant_cnt
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one enable-gated register among NUM_REQ writers.
// Grant, enable and data are registered; the register itself lives outside.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  shared_reg_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt_q;
  logic               reg_en_q;
  logic [WIDTH-1:0]   reg_in_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic [31:0]        idx;
  logic [WIDTH-1:0]   win_data;
  logic               grant;

  // The requester granted this cycle sits out one arbitration.
  assign eligible = bus.req & ~gnt_q;
  assign grant    = found & ~bus.stall;

  // Search from pointer+1 upward, wrapping; first eligible index wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Select the winner's data slice.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) win_data = bus.wr_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant state; reset clears outputs asynchronously and puts requester 0 first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= '0;
      reg_en_q <= 1'b0;
      reg_in_q <= '0;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      cnt_q    <= '0;
    end else if (grant) begin
      gnt_q    <= NUM_REQ'(1) << win;
      reg_en_q <= 1'b1;
      reg_in_q <= win_data;
      ptr_q    <= win;
      cnt_q    <= cnt_q + CNT_W'(1);
    end else begin
      // reg_in keeps its last value; pointer stays put.
      gnt_q    <= '0;
      reg_en_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.reg_en    = reg_en_q;
  assign bus.reg_in    = reg_in_q;
  assign bus.grant_cnt = cnt_q;
  // Pending work indicator only; not a grant.
  assign bus.busy      = |(bus.req & ~gnt_q);

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares a single enable-gated storage register (inputs en/in) among NUM_REQ requesters.
- Each cycle it selects at most one pending writer, drives the register's enable and data, and returns a one-hot grant.
- Sits between requester logic and the shared flip-flop/register bank; the register itself stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, register data width
CNT_W, 16, width of the grant counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted; release synchronous to clk by the environment)
req  input  NUM_REQ  per-requester write request, level
wr_data  input  NUM_REQ*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH]
stall  input  1  downstream hold; when 1 no grant is issued
gnt  output  NUM_REQ  one-hot grant, registered
reg_en  output  1  enable to shared register, registered
reg_in  output  WIDTH  data to shared register, registered
busy  output  1  combinational OR of unmasked req
grant_cnt  output  CNT_W  total grants issued since reset

Behaviour:
- Reset (rst=0, async): gnt=0, reg_en=0, reg_in=0, grant_cnt=0, last-grant pointer=NUM_REQ-1, so requester 0 has first priority after reset.
- Reset mid-operation: all outputs clear immediately, without waiting for clk. Any in-flight grant is dropped. Requesters re-arbitrate after release.
- Arbitration happens on every rising edge with rst=1:
  - eligible[i] = req[i] & ~gnt[i]. The requester granted in the current cycle is masked for one arbitration.
  - Search order: pointer+1, pointer+2, ... wrapping modulo NUM_REQ. The first eligible index wins.
  - If a winner exists and stall=0: next gnt = one-hot(winner), reg_en=1, reg_in = wr_data slice of winner sampled at that edge, pointer=winner, grant_cnt+1.
  - If no winner or stall=1: gnt=0, reg_en=0, reg_in holds its previous value, pointer unchanged.
- Latency: req and data sampled at edge k. gnt, reg_en and reg_in are valid during cycle k..k+1. The shared register captures reg_in at edge k+1.
- Handshake: a requester holds req and wr_data stable until it sees its gnt bit high. One gnt pulse equals exactly one register write.
  - The requester may drop req in the gnt cycle. If req stays high it is a new request, eligible again one cycle later.
- Throughput:
  - One grant per cycle overall.
  - A single persistent requester gets at most every other cycle.
  - Two or more persistent requesters alternate every cycle.
- Fairness: with all req high, the grant order is 0,1,2,...,NUM_REQ-1,0,... With k persistent requesters, each waits at most k-1 grants.
- gnt is always one-hot or zero. reg_en == |gnt at all times.
- grant_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- stall asserted while a gnt is high does not cancel the current grant; it only blocks the next one. Pending requests persist across stall.
- busy = |(req & ~gnt). It is combinational and is not a grant.
- Assertions the bench must carry, disabled while rst=0:
  - onehot0(gnt)
  - reg_en == |gnt
  - gnt[i] |-> $past(req[i])
  - reg_en |-> reg_in == $past(wr_data slice)
  - stall |=> !reg_en
  - after rst release, all outputs equal 0 until the first req.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then pulse rst=0 for 3 ns mid-grant -> gnt=0, reg_en=0, reg_in=0, grant_cnt=0 within 1 ns, with no clk edge required.
- Single requester: req=4'b0100, wr_data slice2=8'hA5 held high for 6 cycles -> gnt=4'b0100 on alternate cycles (3 pulses), reg_in=8'hA5 each time, grant_cnt=3.
- All requesting: req=4'b1111 held for 8 cycles after reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; reg_in follows each slice.
- Wrap and skip: pointer=2 (last grant to requester 2), req=4'b0011 -> next gnt=0001 then 0010, not 0010 first.
- Stall: req=4'b1111, stall=1 for 4 cycles -> reg_en=0 and gnt=0 throughout, reg_in unchanged. Stall released -> grant resumes at pointer+1 on the next edge.
- Random: 10000 cycles of random req, data and stall (stall ~10%) -> no assertion failures. grant_cnt equals the count of reg_en cycles mod 2^16. No eligible requester waits more than NUM_REQ-1 grants.
